// File: rtl/call_ret_ctrl_pkg.sv
// Shared core definitions for the call/return controller: default widths and FSM state encodings.
package call_ret_ctrl_pkg;

    localparam int WIDTH_DEF = 11;
    localparam int DEPTH_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CALL     = 2'd1,
        ST_RET_WAIT = 2'd2,
        ST_RET_LOAD = 2'd3
    } state_t;

endpackage

// File: rtl/stack_depth_counter.sv
// Saturating occupancy counter for the return-address stack (range 0..2^DEPTH).
module stack_depth_counter
    import call_ret_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic             full,
    output logic             empty,
    output logic [DEPTH:0]   count
);

    localparam logic [DEPTH:0] MAX_COUNT = {1'b1, {DEPTH{1'b0}}};

    assign full  = (count == MAX_COUNT);
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/call_ret_ctrl.sv
// Call/return controller: sequences pushes/pops on the return-address stack and redirects the PC.
module call_ret_ctrl
    import call_ret_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             call_req,
    input  logic             ret_req,
    input  logic [WIDTH-1:0] call_target,
    input  logic [WIDTH-1:0] pc_plus1,
    input  logic             clr_err,
    output logic             ack,
    output logic             stall,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_d,
    input  logic [WIDTH-1:0] stk_q,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_next,
    output logic [DEPTH:0]   depth,
    output logic             overflow,
    output logic             underflow
);

    state_t           state;
    logic [WIDTH-1:0] pc_next_reg;
    logic             full;
    logic             empty;
    logic             call_go;
    logic             ret_go;
    logic             ovf_set;
    logic             unf_set;

    // A call always wins over a simultaneous return; the return is simply dropped.
    assign ack     = (state == ST_IDLE) && (call_req || ret_req);
    assign call_go = ack && call_req && !full;
    assign ovf_set = ack && call_req && full;
    assign ret_go  = ack && !call_req && ret_req && !empty;
    assign unf_set = ack && !call_req && ret_req && empty;

    // Occupancy moves at acceptance so a back-to-back request sees the updated depth.
    stack_depth_counter #(.DEPTH(DEPTH)) u_depth (
        .clk   (clk),
        .reset (reset),
        .inc   (call_go),
        .dec   (ret_go),
        .full  (full),
        .empty (empty),
        .count (depth)
    );

    // The popped top-of-stack only becomes valid in RET_LOAD, so it bypasses the register there.
    assign pc_next = (state == ST_RET_LOAD) ? stk_q : pc_next_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            stk_push    <= 1'b0;
            stk_pop     <= 1'b0;
            stk_d       <= '0;
            pc_load     <= 1'b0;
            pc_next_reg <= '0;
            stall       <= 1'b0;
        end else begin
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            pc_load  <= 1'b0;
            stall    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (call_go) begin
                        state       <= ST_CALL;
                        stk_push    <= 1'b1;
                        stk_d       <= pc_plus1;
                        pc_load     <= 1'b1;
                        pc_next_reg <= call_target;
                        stall       <= 1'b1;
                    end else if (ret_go) begin
                        state   <= ST_RET_WAIT;
                        stk_pop <= 1'b1;
                        stall   <= 1'b1;
                    end
                end
                ST_CALL: begin
                    state <= ST_IDLE;
                end
                ST_RET_WAIT: begin
                    state   <= ST_RET_LOAD;
                    pc_load <= 1'b1;
                    stall   <= 1'b1;
                end
                ST_RET_LOAD: begin
                    state       <= ST_IDLE;
                    pc_next_reg <= stk_q;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; clearing beats a same-cycle set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) overflow  <= 1'b1;
            if (unf_set) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Directed self-checking bench for call_ret_ctrl with a small behavioural return-address stack attached.
module tb_call_ret_ctrl;

    localparam int WIDTH = 11;
    localparam int DEPTH = 7;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             call_req = 1'b0;
    logic             ret_req = 1'b0;
    logic [WIDTH-1:0] call_target = '0;
    logic [WIDTH-1:0] pc_plus1 = '0;
    logic             clr_err = 1'b0;
    logic             ack;
    logic             stall;
    logic             stk_push;
    logic             stk_pop;
    logic [WIDTH-1:0] stk_d;
    logic [WIDTH-1:0] stk_q;
    logic             pc_load;
    logic [WIDTH-1:0] pc_next;
    logic [DEPTH:0]   depth;
    logic             overflow;
    logic             underflow;

    int total = 0;
    int bad = 0;

    call_ret_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .call_req    (call_req),
        .ret_req     (ret_req),
        .call_target (call_target),
        .pc_plus1    (pc_plus1),
        .clr_err     (clr_err),
        .ack         (ack),
        .stall       (stall),
        .stk_push    (stk_push),
        .stk_pop     (stk_pop),
        .stk_d       (stk_d),
        .stk_q       (stk_q),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .depth       (depth),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // Attached stack: registered read, top-of-stack valid the cycle after a pop.
    logic [WIDTH-1:0] mem [0:127];
    int sp;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= 0;
            stk_q <= '0;
        end else if (stk_push && sp < 128) begin
            mem[sp] <= stk_d;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_q <= mem[sp-1];
            sp    <= sp - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete accepted call: request at negedge, drop after accept edge, end in the CALL cycle.
    task automatic do_call(input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] ret_addr);
        @(negedge clk);
        call_req    = 1'b1;
        call_target = tgt;
        pc_plus1    = ret_addr;
        @(posedge clk);
        #1 call_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset state while reset is held
        @(negedge clk);
        check("rst_push", 32'(stk_push), 32'd0);
        check("rst_pc_load", 32'(pc_load), 32'd0);
        check("rst_depth", 32'(depth), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ack", 32'(ack), 32'd0);
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_ovf", 32'(overflow), 32'd0);

        // Basic call
        call_req = 1'b1; call_target = 11'h100; pc_plus1 = 11'h023;
        #1 check("call_ack", 32'(ack), 32'd1);
        @(posedge clk);
        #1 call_req = 1'b0;
        @(negedge clk);
        check("call_push", 32'(stk_push), 32'd1);
        check("call_d", 32'(stk_d), 32'h023);
        check("call_pc_load", 32'(pc_load), 32'd1);
        check("call_pc_next", 32'(pc_next), 32'h100);
        check("call_stall", 32'(stall), 32'd1);
        check("call_depth", 32'(depth), 32'd1);
        check("call_busy_ack", 32'(ack), 32'd0);
        @(negedge clk);
        check("call_push_end", 32'(stk_push), 32'd0);
        check("call_stall_end", 32'(stall), 32'd0);

        // Basic return
        ret_req = 1'b1;
        #1 check("ret_ack", 32'(ack), 32'd1);
        @(posedge clk);
        #1 ret_req = 1'b0;
        @(negedge clk);
        check("ret_pop", 32'(stk_pop), 32'd1);
        check("ret_wait_pc_load", 32'(pc_load), 32'd0);
        check("ret_wait_stall", 32'(stall), 32'd1);
        check("ret_depth", 32'(depth), 32'd0);
        @(negedge clk);
        check("ret_load_pop", 32'(stk_pop), 32'd0);
        check("ret_pc_load", 32'(pc_load), 32'd1);
        check("ret_pc_next", 32'(pc_next), 32'h023);
        check("ret_load_stall", 32'(stall), 32'd1);
        @(negedge clk);
        check("ret_stall_end", 32'(stall), 32'd0);

        // Return on empty stack
        ret_req = 1'b1;
        #1 check("unf_ack", 32'(ack), 32'd1);
        @(posedge clk);
        #1 ret_req = 1'b0;
        @(negedge clk);
        check("unf_pop", 32'(stk_pop), 32'd0);
        check("unf_pc_load", 32'(pc_load), 32'd0);
        check("unf_flag", 32'(underflow), 32'd1);
        @(negedge clk);
        check("unf_sticky", 32'(underflow), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("unf_clear", 32'(underflow), 32'd0);

        // Simultaneous call and return at depth 3
        do_call(11'h101, 11'h011);
        do_call(11'h102, 11'h022);
        do_call(11'h103, 11'h033);
        @(negedge clk);
        check("both_depth3", 32'(depth), 32'd3);
        call_req = 1'b1; ret_req = 1'b1; call_target = 11'h200; pc_plus1 = 11'h044;
        #1 check("both_ack", 32'(ack), 32'd1);
        @(posedge clk);
        #1 begin call_req = 1'b0; ret_req = 1'b0; end
        @(negedge clk);
        check("both_push", 32'(stk_push), 32'd1);
        check("both_pop", 32'(stk_pop), 32'd0);
        check("both_pc_next", 32'(pc_next), 32'h200);
        check("both_depth", 32'(depth), 32'd4);
        @(negedge clk);
        check("both_no_pop", 32'(stk_pop), 32'd0);
        check("both_depth_hold", 32'(depth), 32'd4);

        // Return from depth 4 yields the latest return address
        ret_req = 1'b1;
        @(posedge clk);
        #1 ret_req = 1'b0;
        @(negedge clk);
        check("ret4_depth", 32'(depth), 32'd3);
        @(negedge clk);
        check("ret4_pc_next", 32'(pc_next), 32'h044);

        // Reset during RET_WAIT
        @(negedge clk);
        ret_req = 1'b1;
        @(posedge clk);
        #1 ret_req = 1'b0;
        @(negedge clk);
        check("mid_pop", 32'(stk_pop), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_pop", 32'(stk_pop), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_pc_load", 32'(pc_load), 32'd0);
        check("mid_rst_pc_next", 32'(pc_next), 32'd0);
        check("mid_rst_depth", 32'(depth), 32'd0);
        call_req = 1'b1;
        #1 check("mid_rst_idle", 32'(ack), 32'd1);
        call_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Fill to capacity, then overflow
        for (int i = 0; i < 128; i++) begin
            do_call(WIDTH'(i + 16'h300), WIDTH'(i));
        end
        @(negedge clk);
        check("full_depth", 32'(depth), 32'd128);
        check("full_ovf_clear", 32'(overflow), 32'd0);
        call_req = 1'b1; call_target = 11'h7AA; pc_plus1 = 11'h055;
        #1 check("ovf_ack", 32'(ack), 32'd1);
        @(posedge clk);
        #1 call_req = 1'b0;
        @(negedge clk);
        check("ovf_push", 32'(stk_push), 32'd0);
        check("ovf_pc_load", 32'(pc_load), 32'd0);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_depth", 32'(depth), 32'd128);

        // Clear beats a same-cycle overflowing call
        call_req = 1'b1; clr_err = 1'b1;
        @(posedge clk);
        #1 begin call_req = 1'b0; clr_err = 1'b0; end
        @(negedge clk);
        check("clr_priority", 32'(overflow), 32'd0);
        check("clr_depth", 32'(depth), 32'd128);

        // Top of a full stack returns correctly
        ret_req = 1'b1;
        @(posedge clk);
        #1 ret_req = 1'b0;
        @(negedge clk);
        check("full_ret_depth", 32'(depth), 32'd127);
        @(negedge clk);
        check("full_ret_pc_next", 32'(pc_next), 32'd127);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/call_ret_ctrl.md
CALL_RET_CTRL -- requirements
Module: call_ret_ctrl

Interface
REQ-001 Parameter WIDTH, default 11, SHALL set the return-address and program-counter width.
REQ-002 Parameter DEPTH, default 7, SHALL set log2 of the attached stack's entry count (capacity 2^DEPTH = 128).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 call_req  input  1  SHALL be the call request from decode, held until ack.
REQ-006 ret_req  input  1  SHALL be the return request from decode, held until ack.
REQ-007 call_target  input  WIDTH  SHALL be the jump destination of a call.
REQ-008 pc_plus1  input  WIDTH  SHALL be the return address to save on a call.
REQ-009 clr_err  input  1  SHALL clear the sticky error flags.
REQ-010 ack  output  1  SHALL indicate request acceptance (combinational).
REQ-011 stall  output  1  SHALL hold the fetch stage while a call/return is in progress.
REQ-012 stk_push, stk_pop  output  1 each  SHALL be single-cycle stack commands.
REQ-013 stk_d  output  WIDTH  SHALL be push data; stk_q  input  WIDTH  SHALL be top-of-stack, valid one cycle after stk_pop.
REQ-014 pc_load  output  1, pc_next  output  WIDTH  SHALL redirect the program counter.
REQ-015 depth  output  DEPTH+1  SHALL be the current stack occupancy.
REQ-016 overflow, underflow  output  1 each  SHALL be the sticky error flags.

Function
REQ-017 FSM states: IDLE, CALL, RET_WAIT, RET_LOAD.
REQ-018 ack SHALL be 1 iff state==IDLE and (call_req or ret_req); requester deasserts its request the cycle after ack.
REQ-019 call_req and ret_req both high in IDLE: call SHALL win and ret SHALL be dropped (not acked separately).
REQ-020 Accepted call with depth<2^DEPTH: IDLE->CALL; in CALL cycle stk_push=1, stk_d=captured pc_plus1, pc_load=1, pc_next=captured call_target, stall=1, depth+1; CALL->IDLE.
REQ-021 Accepted call with depth==2^DEPTH: no push, no pc_load, overflow set; state stays IDLE.
REQ-022 Accepted ret with depth>0: IDLE->RET_WAIT; RET_WAIT: stk_pop=1, stall=1, depth-1; RET_LOAD: pc_load=1, pc_next=stk_q, stall=1; RET_LOAD->IDLE.
REQ-023 Accepted ret with depth==0: no pop, no pc_load, underflow set; state stays IDLE.
REQ-024 Requests while state!=IDLE SHALL be ignored (ack=0).
REQ-025 stk_push and stk_pop SHALL never be high in the same cycle; each high at most one cycle per operation.
REQ-026 Latency: call 1 cycle after ack, return redirect 2 cycles after ack.
REQ-027 overflow/underflow SHALL stay set until clr_err or reset; clr_err has priority over a same-cycle set.
REQ-028 depth SHALL saturate in range 0..2^DEPTH and never wrap.

Reset
REQ-029 reset high SHALL immediately force state IDLE, depth 0, overflow/underflow 0, and stk_push, stk_pop, pc_load, stall, stk_d, pc_next to 0, including mid-operation.
REQ-030 The attached stack SHALL share the same reset so its pointer and depth stay consistent.

Structure
REQ-031 WIDTH, DEPTH defaults and FSM state encodings SHALL live in the shared core definitions package.
REQ-032 The occupancy counter SHALL be a sub-module stack_depth_counter (inc, dec, full, empty, count).

Verification
REQ-033 After reset, call_req, call_target=0x100, pc_plus1=0x023 -> ack, next cycle stk_push=1, stk_d=0x023, pc_load=1, pc_next=0x100, depth=1.
REQ-034 Then ret_req with stk_q=0x023 -> stk_pop=1 at +1, pc_load=1 pc_next=0x023 at +2, stall high both cycles, depth=0.
REQ-035 128 calls then a 129th -> depth=128, 129th: no push/pc_load, overflow=1; clr_err -> overflow=0.
REQ-036 ret_req at depth 0 -> ack, no stk_pop, no pc_load, underflow=1.
REQ-037 call_req and ret_req together at depth 3 -> one push, no pop, depth=4.
REQ-038 reset asserted during RET_WAIT -> outputs 0 without waiting for an edge, state IDLE, depth 0.
